// File: rtl/cc_stream_arbiter.sv
// Packet-atomic round-robin arbiter merging two CC AXI-Stream sources onto one registered output.
// Define CC_STREAM_ARB_STATS_EN to enable the per-source forwarded-packet counters.
module cc_stream_arbiter #(
  parameter int IF_WIDTH       = 512,
  parameter int TKEEP_WIDTH    = 16,
  parameter int CC_TUSER_WIDTH = 81
) (
  input  logic                      user_clk,
  input  logic                      user_rst,
  input  logic [IF_WIDTH-1:0]       conv_tdata,
  input  logic [TKEEP_WIDTH-1:0]    conv_tkeep,
  input  logic                      conv_tlast,
  input  logic [CC_TUSER_WIDTH-1:0] conv_tuser,
  input  logic                      conv_tvalid,
  output logic                      conv_tready,
  input  logic [IF_WIDTH-1:0]       local_tdata,
  input  logic [TKEEP_WIDTH-1:0]    local_tkeep,
  input  logic                      local_tlast,
  input  logic [CC_TUSER_WIDTH-1:0] local_tuser,
  input  logic                      local_tvalid,
  output logic                      local_tready,
  output logic [IF_WIDTH-1:0]       s_axis_cc_tdata,
  output logic [TKEEP_WIDTH-1:0]    s_axis_cc_tkeep,
  output logic                      s_axis_cc_tlast,
  output logic [CC_TUSER_WIDTH-1:0] s_axis_cc_tuser,
  output logic                      s_axis_cc_tvalid,
  input  logic                      s_axis_cc_tready,
  output logic [31:0]               pkt_cnt_conv,
  output logic [31:0]               pkt_cnt_local
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_nxt;
  logic   grant, grant_nxt, rr_last;
  logic   out_vld;
  logic   src_rdy, src_vld, src_last, xfer, eop;
  logic   own_vld, other_vld;

  // Ready is gated by reset so a source never sees a handshake during reset.
  assign src_rdy      = (state == BUSY) && (!out_vld || s_axis_cc_tready) && !user_rst;
  assign src_vld      = grant ? local_tvalid : conv_tvalid;
  assign src_last     = grant ? local_tlast  : conv_tlast;
  assign conv_tready  = src_rdy && !grant;
  assign local_tready = src_rdy && grant;
  assign xfer         = src_rdy && src_vld;
  assign eop          = xfer && src_last;
  assign own_vld      = grant ? local_tvalid : conv_tvalid;
  assign other_vld    = grant ? conv_tvalid  : local_tvalid;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        if (conv_tvalid || local_tvalid) begin
          state_nxt = BUSY;
          grant_nxt = (conv_tvalid && local_tvalid) ? ~rr_last : local_tvalid;
        end
      end
      BUSY: begin
        // Re-arbitrate on the last beat for a zero-bubble handoff.
        if (eop) begin
          if (other_vld)    grant_nxt = ~grant;
          else if (own_vld) grant_nxt = grant;
          else              state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state   <= IDLE;
      grant   <= 1'b0;
      rr_last <= 1'b1;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (eop) rr_last <= grant;
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      out_vld         <= 1'b0;
      s_axis_cc_tdata <= '0;
      s_axis_cc_tkeep <= '0;
      s_axis_cc_tlast <= 1'b0;
      s_axis_cc_tuser <= '0;
    end else if (xfer) begin
      out_vld         <= 1'b1;
      s_axis_cc_tdata <= grant ? local_tdata : conv_tdata;
      s_axis_cc_tkeep <= grant ? local_tkeep : conv_tkeep;
      s_axis_cc_tlast <= src_last;
      s_axis_cc_tuser <= grant ? local_tuser : conv_tuser;
    end else if (s_axis_cc_tready) begin
      out_vld <= 1'b0;
    end
  end

  assign s_axis_cc_tvalid = out_vld;

`ifdef CC_STREAM_ARB_STATS_EN
  logic [31:0] cnt_conv, cnt_local;

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      cnt_conv  <= '0;
      cnt_local <= '0;
    end else if (eop) begin
      if (grant) cnt_local <= cnt_local + 32'd1;
      else       cnt_conv  <= cnt_conv + 32'd1;
    end
  end

  assign pkt_cnt_conv  = cnt_conv;
  assign pkt_cnt_local = cnt_local;
`else
  assign pkt_cnt_conv  = '0;
  assign pkt_cnt_local = '0;
`endif

endmodule

// File: tb/tb_cc_stream_arbiter.sv
// Directed self-checking bench for cc_stream_arbiter: reset, single source, interleave, grant lock, backpressure, stats.
module tb_cc_stream_arbiter;
  localparam int IW = 512;
  localparam int KW = 16;
  localparam int UW = 81;

  logic          user_clk = 1'b0;
  logic          user_rst = 1'b1;
  logic [IW-1:0] conv_tdata = '0, local_tdata = '0, s_axis_cc_tdata;
  logic [KW-1:0] conv_tkeep = 16'h00FF, local_tkeep = 16'hF0F0, s_axis_cc_tkeep;
  logic [UW-1:0] conv_tuser = 81'h5, local_tuser = 81'h7, s_axis_cc_tuser;
  logic          conv_tlast = 1'b0, local_tlast = 1'b0, s_axis_cc_tlast;
  logic          conv_tvalid = 1'b0, local_tvalid = 1'b0, s_axis_cc_tvalid;
  logic          conv_tready, local_tready;
  logic          s_axis_cc_tready = 1'b1;
  logic [31:0]   pkt_cnt_conv, pkt_cnt_local;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  cc_stream_arbiter #(.IF_WIDTH(IW), .TKEEP_WIDTH(KW), .CC_TUSER_WIDTH(UW)) dut (
    .user_clk(user_clk), .user_rst(user_rst),
    .conv_tdata(conv_tdata), .conv_tkeep(conv_tkeep), .conv_tlast(conv_tlast),
    .conv_tuser(conv_tuser), .conv_tvalid(conv_tvalid), .conv_tready(conv_tready),
    .local_tdata(local_tdata), .local_tkeep(local_tkeep), .local_tlast(local_tlast),
    .local_tuser(local_tuser), .local_tvalid(local_tvalid), .local_tready(local_tready),
    .s_axis_cc_tdata(s_axis_cc_tdata), .s_axis_cc_tkeep(s_axis_cc_tkeep),
    .s_axis_cc_tlast(s_axis_cc_tlast), .s_axis_cc_tuser(s_axis_cc_tuser),
    .s_axis_cc_tvalid(s_axis_cc_tvalid), .s_axis_cc_tready(s_axis_cc_tready),
    .pkt_cnt_conv(pkt_cnt_conv), .pkt_cnt_local(pkt_cnt_local)
  );

  always #5 user_clk = ~user_clk;
  always @(posedge user_clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, want finish before 300000");
    $fatal(1);
  end

  // Output monitor: collects accepted beats and checks the AXI hold rule.
  typedef struct {logic [15:0] d; logic l; int c;} beat_t;
  beat_t       outq[$];
  bit          mon_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_d = '0;

  always @(negedge user_clk) begin
    if (mon_en && !user_rst) begin
      if (prev_stall) begin
        checks++;
        if (s_axis_cc_tvalid !== 1'b1 || s_axis_cc_tdata[15:0] !== prev_d) begin
          errors++;
          $display("FAIL hold_stable: got vld=%b data=%h, want vld=1 data=%h",
                   s_axis_cc_tvalid, s_axis_cc_tdata[15:0], prev_d);
        end
      end
      if (s_axis_cc_tvalid && !s_axis_cc_tready) begin
        checks++;
        if ({conv_tready, local_tready} !== 2'b00) begin
          errors++;
          $display("FAIL stall_ready: got conv/local ready=%b%b, want 00", conv_tready, local_tready);
        end
      end
      if (s_axis_cc_tvalid && s_axis_cc_tready)
        outq.push_back('{s_axis_cc_tdata[15:0], s_axis_cc_tlast, cyc});
      prev_stall <= s_axis_cc_tvalid && !s_axis_cc_tready;
      prev_d     <= s_axis_cc_tdata[15:0];
    end else begin
      prev_stall <= 1'b0;
    end
  end

  task automatic reset_dut();
    user_rst = 1'b1;
    conv_tvalid = 1'b0; local_tvalid = 1'b0;
    conv_tlast = 1'b0; local_tlast = 1'b0;
    s_axis_cc_tready = 1'b1;
    repeat (2) begin @(posedge user_clk); #1; end
    user_rst = 1'b0;
    outq.delete();
  endtask

  // Sends npkt packets of nb beats; data = base + running beat index.
  task automatic drive_src(input bit src, input int npkt, input int nb, input logic [15:0] base);
    bit          hs;
    int          wait_n;
    logic [15:0] v;
    for (int p = 0; p < npkt; p++) begin
      for (int i = 0; i < nb; i++) begin
        v = base + 16'(p * nb + i);
        if (src) begin
          local_tvalid = 1'b1; local_tdata = {{(IW-16){1'b0}}, v}; local_tlast = (i == nb - 1);
        end else begin
          conv_tvalid = 1'b1; conv_tdata = {{(IW-16){1'b0}}, v}; conv_tlast = (i == nb - 1);
        end
        wait_n = 0;
        do begin
          @(negedge user_clk);
          hs = src ? local_tready : conv_tready;
          @(posedge user_clk); #1;
          wait_n++;
        end while (!hs && wait_n < 100);
        if (!hs) begin
          checks++; errors++;
          $display("FAIL drive_timeout: src=%0d beat %h not accepted, want accept within 100 cycles", src, v);
          if (src) local_tvalid = 1'b0; else conv_tvalid = 1'b0;
          return;
        end
      end
    end
    if (src) begin local_tvalid = 1'b0; local_tlast = 1'b0; end
    else begin conv_tvalid = 1'b0; conv_tlast = 1'b0; end
  endtask

  task automatic test_reset();
    user_rst = 1'b1;
    conv_tvalid = 1'b1; conv_tdata = {{(IW-8){1'b0}}, 8'hAA}; conv_tlast = 1'b1;
    local_tvalid = 1'b1; local_tdata = {{(IW-8){1'b0}}, 8'hBB}; local_tlast = 1'b1;
    s_axis_cc_tready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge user_clk); #1;
      checks++;
      if (s_axis_cc_tvalid !== 1'b0 || s_axis_cc_tdata !== '0) begin
        errors++;
        $display("FAIL reset_out[%0d]: got vld=%b data=%h, want 0/0", k, s_axis_cc_tvalid, s_axis_cc_tdata[15:0]);
      end
      checks++;
      if (conv_tready !== 1'b0 || local_tready !== 1'b0) begin
        errors++;
        $display("FAIL reset_ready[%0d]: got %b%b, want 00", k, conv_tready, local_tready);
      end
    end
    user_rst = 1'b0;
    @(posedge user_clk); #1;
    checks++;
    if (conv_tready !== 1'b1 || local_tready !== 1'b0) begin
      errors++;
      $display("FAIL first_grant: got conv/local ready=%b%b, want 10", conv_tready, local_tready);
    end
    @(posedge user_clk); #1;
    conv_tvalid = 1'b0;
    #1;
    checks++;
    if (s_axis_cc_tvalid !== 1'b1 || s_axis_cc_tdata[15:0] !== 16'hAA || s_axis_cc_tlast !== 1'b1 ||
        s_axis_cc_tkeep !== 16'h00FF || s_axis_cc_tuser !== 81'h5) begin
      errors++;
      $display("FAIL first_beat: got vld=%b data=%h last=%b keep=%h, want 1 00aa 1 00ff",
               s_axis_cc_tvalid, s_axis_cc_tdata[15:0], s_axis_cc_tlast, s_axis_cc_tkeep);
    end
    checks++;
    if (local_tready !== 1'b1 || conv_tready !== 1'b0) begin
      errors++;
      $display("FAIL handoff_ready: got conv/local ready=%b%b, want 01", conv_tready, local_tready);
    end
    @(posedge user_clk); #1;
    local_tvalid = 1'b0;
    #1;
    checks++;
    if (s_axis_cc_tdata[15:0] !== 16'hBB || s_axis_cc_tkeep !== 16'hF0F0 || s_axis_cc_tuser !== 81'h7) begin
      errors++;
      $display("FAIL local_beat: got data=%h keep=%h, want 00bb f0f0", s_axis_cc_tdata[15:0], s_axis_cc_tkeep);
    end
  endtask

  task automatic test_conv_only();
    int cv[6] = '{1, 1, 1, 1, 0, 0};
    int cd[6] = '{1, 1, 2, 3, 0, 0};
    int cl[6] = '{0, 0, 0, 1, 0, 0};
    int er[6] = '{0, 1, 1, 1, 1, 1};
    int ov[6] = '{0, 0, 1, 1, 1, 0};
    int od[6] = '{0, 0, 1, 2, 3, 0};
    int ol[6] = '{0, 0, 0, 0, 1, 0};
    reset_dut();
    for (int k = 0; k < 6; k++) begin
      conv_tvalid = cv[k][0]; conv_tdata = {{(IW-32){1'b0}}, 32'(cd[k])}; conv_tlast = cl[k][0];
      #1;
      checks++;
      if (conv_tready !== er[k][0] || local_tready !== 1'b0) begin
        errors++;
        $display("FAIL conv_only_ready[%0d]: got %b%b, want %b0", k, conv_tready, local_tready, er[k][0]);
      end
      checks++;
      if (s_axis_cc_tvalid !== ov[k][0] ||
          (ov[k] != 0 && (s_axis_cc_tdata !== {{(IW-32){1'b0}}, 32'(od[k])} || s_axis_cc_tlast !== ol[k][0]))) begin
        errors++;
        $display("FAIL conv_only_out[%0d]: got vld=%b data=%h last=%b, want %b %h %b", k,
                 s_axis_cc_tvalid, s_axis_cc_tdata[15:0], s_axis_cc_tlast, ov[k][0], od[k][15:0], ol[k][0]);
      end
      @(posedge user_clk); #1;
    end
  endtask

  task automatic test_grant_lock();
    int cv[7]  = '{1, 1, 1, 1, 1, 0, 0};
    int cd[7]  = '{'hC0, 'hC0, 'hC1, 'hC2, 'hC3, 0, 0};
    int cl[7]  = '{0, 0, 0, 0, 1, 0, 0};
    int lv[7]  = '{0, 0, 1, 1, 1, 1, 0};
    int erc[7] = '{0, 1, 1, 1, 1, 0, 0};
    int erl[7] = '{0, 0, 0, 0, 0, 1, 1};
    int ov[7]  = '{0, 0, 1, 1, 1, 1, 1};
    int od[7]  = '{0, 0, 'hC0, 'hC1, 'hC2, 'hC3, 'hD0};
    int ol[7]  = '{0, 0, 0, 0, 0, 1, 1};
    reset_dut();
    local_tdata = {{(IW-8){1'b0}}, 8'hD0}; local_tlast = 1'b1;
    for (int k = 0; k < 7; k++) begin
      conv_tvalid = cv[k][0]; conv_tdata = {{(IW-32){1'b0}}, 32'(cd[k])}; conv_tlast = cl[k][0];
      local_tvalid = lv[k][0];
      #1;
      checks++;
      if (conv_tready !== erc[k][0] || local_tready !== erl[k][0]) begin
        errors++;
        $display("FAIL lock_ready[%0d]: got %b%b, want %b%b", k, conv_tready, local_tready, erc[k][0], erl[k][0]);
      end
      checks++;
      if (s_axis_cc_tvalid !== ov[k][0] ||
          (ov[k] != 0 && (s_axis_cc_tdata !== {{(IW-32){1'b0}}, 32'(od[k])} || s_axis_cc_tlast !== ol[k][0]))) begin
        errors++;
        $display("FAIL lock_out[%0d]: got vld=%b data=%h last=%b, want %b %h %b", k,
                 s_axis_cc_tvalid, s_axis_cc_tdata[15:0], s_axis_cc_tlast, ov[k][0], od[k][15:0], ol[k][0]);
      end
      @(posedge user_clk); #1;
    end
    local_tlast = 1'b0;
  endtask

  // Both sources saturated: packets must alternate conv/local with no gaps.
  task automatic test_interleave(input int nb, input int npkt);
    int          src, spkt, beat;
    logic [15:0] ed;
    reset_dut();
    fork
      drive_src(1'b0, npkt, nb, 16'hA0);
      drive_src(1'b1, npkt, nb, 16'hB0);
    join
    repeat (3) begin @(posedge user_clk); #1; end
    checks++;
    if (outq.size() != 2 * npkt * nb) begin
      errors++;
      $display("FAIL interleave_count(nb=%0d): got %0d beats, want %0d", nb, outq.size(), 2 * npkt * nb);
    end else begin
      for (int j = 0; j < 2 * npkt * nb; j++) begin
        src  = (j / nb) % 2;
        spkt = (j / nb) / 2;
        beat = j % nb;
        ed   = (src != 0 ? 16'hB0 : 16'hA0) + 16'(spkt * nb + beat);
        checks++;
        if (outq[j].d !== ed || outq[j].l !== (beat == nb - 1) || outq[j].c != outq[0].c + j) begin
          errors++;
          $display("FAIL interleave_beat(nb=%0d)[%0d]: got data=%h last=%b cyc=%0d, want %h %b %0d", nb, j,
                   outq[j].d, outq[j].l, outq[j].c, ed, beat == nb - 1, outq[0].c + j);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit done = 1'b0;
    reset_dut();
    fork
      begin drive_src(1'b0, 1, 6, 16'hE0); done = 1'b1; end
      begin
        while (!done) begin
          @(posedge user_clk); #1;
          s_axis_cc_tready = ~s_axis_cc_tready;
        end
      end
    join
    s_axis_cc_tready = 1'b1;
    repeat (3) begin @(posedge user_clk); #1; end
    checks++;
    if (outq.size() != 6) begin
      errors++;
      $display("FAIL bp_count: got %0d beats, want 6", outq.size());
    end else begin
      for (int j = 0; j < 6; j++) begin
        checks++;
        if (outq[j].d !== 16'hE0 + 16'(j) || outq[j].l !== (j == 5)) begin
          errors++;
          $display("FAIL bp_beat[%0d]: got data=%h last=%b, want %h %b", j, outq[j].d, outq[j].l,
                   16'hE0 + 16'(j), j == 5);
        end
      end
    end
  endtask

  task automatic test_stats();
`ifdef CC_STREAM_ARB_STATS_EN
    reset_dut();
    checks++;
    if (pkt_cnt_conv !== 32'd0 || pkt_cnt_local !== 32'd0) begin
      errors++;
      $display("FAIL stats_reset: got %0d/%0d, want 0/0", pkt_cnt_conv, pkt_cnt_local);
    end
    fork
      drive_src(1'b0, 5, 1, 16'h10);
      drive_src(1'b1, 3, 2, 16'h20);
    join
    repeat (2) begin @(posedge user_clk); #1; end
    checks++;
    if (pkt_cnt_conv !== 32'd5 || pkt_cnt_local !== 32'd3) begin
      errors++;
      $display("FAIL stats_count: got %0d/%0d, want 5/3", pkt_cnt_conv, pkt_cnt_local);
    end
    reset_dut();
    force dut.cnt_conv = 32'hFFFF_FFFF;
    @(posedge user_clk); #1;
    release dut.cnt_conv;
    drive_src(1'b0, 1, 2, 16'h30);
    repeat (2) begin @(posedge user_clk); #1; end
    checks++;
    if (pkt_cnt_conv !== 32'd0) begin
      errors++;
      $display("FAIL stats_wrap: got %h, want 00000000", pkt_cnt_conv);
    end
`else
    reset_dut();
    fork
      drive_src(1'b0, 2, 1, 16'h10);
      drive_src(1'b1, 2, 1, 16'h20);
    join
    repeat (2) begin @(posedge user_clk); #1; end
    checks++;
    if (pkt_cnt_conv !== 32'd0 || pkt_cnt_local !== 32'd0) begin
      errors++;
      $display("FAIL stats_disabled: got %0d/%0d, want 0/0", pkt_cnt_conv, pkt_cnt_local);
    end
`endif
  endtask

  initial begin
    test_reset();
    mon_en = 1'b1;
    test_conv_only();
    test_grant_lock();
    test_interleave(2, 2);
    test_interleave(1, 3);
    test_backpressure();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cc_stream_arbiter.md
Name: cc_stream_arbiter

Overview:
- Packet-atomic, round-robin arbiter that shares the single CPM5/PCIe completer-completion (CC) AXI-Stream interface between two CC sources.
- Source 0 (conv_*) carries completions produced by the RC-to-CC conversion path of the two-port switch. Source 1 (local_*) carries completions generated by local switch logic (config/BAR responders).
- Drives s_axis_cc_* through a one-stage registered output pipeline.

Parameters:
- IF_WIDTH, 512, tdata width of all streams.
- TKEEP_WIDTH, 16, tkeep width (dword granularity).
- CC_TUSER_WIDTH, 81, tuser width of all streams.

Ports:
- user_clk  in  1  clock; all logic on rising edge.
- user_rst  in  1  reset, synchronous, active-high.
- conv_tdata  in  IF_WIDTH  source 0 data.
- conv_tkeep  in  TKEEP_WIDTH  source 0 keep.
- conv_tlast  in  1  source 0 last beat.
- conv_tuser  in  CC_TUSER_WIDTH  source 0 user.
- conv_tvalid  in  1  source 0 valid.
- conv_tready  out  1  source 0 ready.
- local_tdata / local_tkeep / local_tlast / local_tuser / local_tvalid  in  same widths as conv_*  source 1 stream.
- local_tready  out  1  source 1 ready.
- s_axis_cc_tdata / tkeep / tlast / tuser / tvalid  out  same widths  merged CC stream to core.
- s_axis_cc_tready  in  1  core ready.
- pkt_cnt_conv  out  32  source 0 packets forwarded (see Optional Feature).
- pkt_cnt_local  out  32  source 1 packets forwarded (see Optional Feature).

Behaviour:
- Reset (user_rst=1 at clock edge):
  - state=IDLE, grant=0, rr_last=1 (source 0 wins first contention).
  - s_axis_cc_tvalid=0; s_axis_cc_tdata/tkeep/tlast/tuser=0.
  - conv_tready=local_tready=0; counters=0.
- FSM states are IDLE and BUSY.
- IDLE:
  - Both tready=0.
  - If any tvalid is high, pick the winner: if both are valid, the source != rr_last wins; otherwise the single valid source wins.
  - Register grant and go to BUSY. This costs one arbitration cycle.
- BUSY:
  - Granted tready = !out_vld || s_axis_cc_tready. Ungranted tready=0, always.
  - A beat transfers when granted tvalid && tready. The beat is loaded into the output register and appears on s_axis_cc_* the next cycle (latency 1).
- Grant lock:
  - Grant is held until a transfer with tlast=1. No switch mid-packet, whatever the other source's tvalid does.
- End of packet (transfer with tlast=1):
  - rr_last <= grant.
  - Arbitrate the same cycle on the current tvalids, excluding the just-completed beat's own source only when the other is valid.
  - If a winner exists, stay BUSY with the new grant (zero-bubble handoff). Otherwise go to IDLE.
- Output register:
  - out_vld set on load.
  - Cleared when s_axis_cc_tready=1 and no load occurs in that cycle.
  - Contents hold stable while out_vld && !s_axis_cc_tready (AXI rule).
- Single-beat packets (tlast on first beat) are legal. Back-to-back single-beat packets from alternating sources run at full rate.
- The block never drops, duplicates or reorders beats within a source.
- tkeep/tuser/tdata pass through unmodified.
- Reset mid-packet: the partial packet is abandoned and the output is cleared. Re-synchronising upstream is the source's responsibility.

Optional Feature:
- Macro: CC_STREAM_ARB_STATS_EN.
- Defined:
  - pkt_cnt_conv / pkt_cnt_local increment by 1 on each tlast transfer from the respective source.
  - 32-bit counters that wrap 0xFFFFFFFF->0. Cleared by user_rst.
- Undefined:
  - Both ports are tied to 0 and no counter flops are inferred.

Test Plan:
- Reset: hold user_rst 3 cycles with both tvalid=1 -> s_axis_cc_tvalid=0, data=0, both tready=0 during reset. The first grant after reset goes to conv.
- conv only sends a 3-beat packet, tdata=1,2,3, s_axis_cc_tready=1 -> one IDLE cycle, then output beats 1,2,3 on consecutive cycles, each 1 cycle after its input transfer; tlast on beat 3; local_tready=0 throughout.
- Both sources send 2-beat packets continuously (conv A0..A3, local B0..B3) -> output packet order conv,local,conv,local. No bubble between packets after the first arbitration.
- local_tvalid rises on beat 2 of a 4-beat conv packet -> local_tready stays 0 until the conv tlast transfer, then local is granted next cycle.
- s_axis_cc_tready pattern 1,0,1,0,... during a 6-beat conv packet -> output shows exactly 6 beats in order; data stable while tready=0; conv_tready low whenever out_vld && !s_axis_cc_tready.
- With CC_STREAM_ARB_STATS_EN: 5 conv + 3 local packets -> pkt_cnt_conv=5, pkt_cnt_local=3. After reset both are 0. Preload 0xFFFFFFFF via force, send one packet -> counter wraps to 0. Without the macro both outputs read 0.
